axi_aw_arbiter: RTL and testbench

//  Write-path arbiter feeding the AXI write address/data/response muxes. Picks one of 3 masters
//  (M0..M2) round-robin, decodes its AWADDR to one of 8 slaves (S0..S7), and holds that route

---
 rtl/axi_aw_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_aw_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_arbiter.sv
// Round-robin AXI write-path arbiter: 3 masters to 8 slaves.
// Holds one route through the AW, W and B phases of a single write.
module axi_aw_arbiter #(
  parameter int SEL_LSB  = 16,
  parameter int LEN_BITS = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [2:0]          AWVALID_M,
  input  logic [31:0]         AWADDR_M0,
  input  logic [31:0]         AWADDR_M1,
  input  logic [31:0]         AWADDR_M2,
  input  logic [LEN_BITS-1:0] AWLEN_M0,
  input  logic [LEN_BITS-1:0] AWLEN_M1,
  input  logic [LEN_BITS-1:0] AWLEN_M2,
  input  logic [7:0]          AWREADY_S,
  input  logic [2:0]          WVALID_M,
  input  logic [2:0]          WLAST_M,
  input  logic [7:0]          WREADY_S,
  input  logic [7:0]          BVALID_S,
  input  logic [2:0]          BREADY_M,
  output logic                aw_sel_valid,
  output logic                w_sel_valid,
  output logic                b_sel_valid,
  output logic [1:0]          sel_mst,
  output logic [2:0]          sel_slv,
  output logic                wlast_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t              state;
  logic [1:0]          rr_ptr;
  logic [LEN_BITS:0]   beat_cnt;
  logic [LEN_BITS-1:0] len_q;

  logic [1:0]          c0, c1, c2, gnt;
  logic [31:0]         gnt_addr;
  logic [LEN_BITS-1:0] gnt_len;
  logic [2:0]          gnt_slv;
  logic [3:0]          awv_x, wv_x, wl_x, br_x;
  logic                aw_hs, beat, b_hs, last_beat;
  logic                unused_addr;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign c0 = rr_ptr;
  assign c1 = nxt(c0);
  assign c2 = nxt(c1);

  always_comb begin
    gnt = c2;
    if (AWVALID_M[c0])
      gnt = c0;
    else if (AWVALID_M[c1])
      gnt = c1;
  end

  always_comb begin
    gnt_addr = AWADDR_M2;
    gnt_len  = AWLEN_M2;
    case (gnt)
      2'd0: begin
        gnt_addr = AWADDR_M0;
        gnt_len  = AWLEN_M0;
      end
      2'd1: begin
        gnt_addr = AWADDR_M1;
        gnt_len  = AWLEN_M1;
      end
      default: begin
        gnt_addr = AWADDR_M2;
        gnt_len  = AWLEN_M2;
      end
    endcase
  end

  assign gnt_slv = gnt_addr[SEL_LSB+2:SEL_LSB];

  // Only the slave-select field of each address is routed here
  assign unused_addr = ^{AWADDR_M0, AWADDR_M1, AWADDR_M2};

  // Pad master vectors so a 2-bit index never falls off the end
  assign awv_x = {1'b0, AWVALID_M};
  assign wv_x  = {1'b0, WVALID_M};
  assign wl_x  = {1'b0, WLAST_M};
  assign br_x  = {1'b0, BREADY_M};

  assign aw_hs     = awv_x[sel_mst] & AWREADY_S[sel_slv];
  assign beat      = wv_x[sel_mst] & WREADY_S[sel_slv];
  assign b_hs      = BVALID_S[sel_slv] & br_x[sel_mst];
  assign last_beat = (beat_cnt == {1'b0, len_q});

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= IDLE;
      rr_ptr       <= 2'd0;
      beat_cnt     <= '0;
      len_q        <= '0;
      aw_sel_valid <= 1'b0;
      w_sel_valid  <= 1'b0;
      b_sel_valid  <= 1'b0;
      sel_mst      <= 2'd0;
      sel_slv      <= 3'd0;
      wlast_err    <= 1'b0;
    end else begin
      wlast_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|AWVALID_M) begin
            state        <= ADDR;
            aw_sel_valid <= 1'b1;
            sel_mst      <= gnt;
            sel_slv      <= gnt_slv;
            len_q        <= gnt_len;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            state        <= DATA;
            aw_sel_valid <= 1'b0;
            w_sel_valid  <= 1'b1;
            beat_cnt     <= '0;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt  <= beat_cnt + 1'b1;
            // Beat count, not WLAST, decides where the burst ends
            wlast_err <= wl_x[sel_mst] ^ last_beat;
            if (last_beat) begin
              state       <= RESP;
              w_sel_valid <= 1'b0;
              b_sel_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            state       <= IDLE;
            b_sel_valid <= 1'b0;
            sel_mst     <= 2'd0;
            sel_slv     <= 3'd0;
            rr_ptr      <= nxt(sel_mst);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Bench for axi_aw_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_axi_aw_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [2:0]  AWVALID_M = '0;
  logic [31:0] AWADDR_M0 = '0, AWADDR_M1 = '0, AWADDR_M2 = '0;
  logic [3:0]  AWLEN_M0 = '0, AWLEN_M1 = '0, AWLEN_M2 = '0;
  logic [7:0]  AWREADY_S = '0;
  logic [2:0]  WVALID_M = '0;
  logic [2:0]  WLAST_M = '0;
  logic [7:0]  WREADY_S = '0;
  logic [7:0]  BVALID_S = '0;
  logic [2:0]  BREADY_M = '0;
  logic        aw_sel_valid, w_sel_valid, b_sel_valid;
  logic [1:0]  sel_mst;
  logic [2:0]  sel_slv;
  logic        wlast_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int grants[$];
  logic aw_prev = 1'b0;
  bit chk_en = 1'b0;

  axi_aw_arbiter #(.SEL_LSB(16), .LEN_BITS(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID_M(AWVALID_M),
    .AWADDR_M0(AWADDR_M0), .AWADDR_M1(AWADDR_M1), .AWADDR_M2(AWADDR_M2),
    .AWLEN_M0(AWLEN_M0), .AWLEN_M1(AWLEN_M1), .AWLEN_M2(AWLEN_M2),
    .AWREADY_S(AWREADY_S), .WVALID_M(WVALID_M), .WLAST_M(WLAST_M),
    .WREADY_S(WREADY_S), .BVALID_S(BVALID_S), .BREADY_M(BREADY_M),
    .aw_sel_valid(aw_sel_valid), .w_sel_valid(w_sel_valid),
    .b_sel_valid(b_sel_valid), .sel_mst(sel_mst), .sel_slv(sel_slv),
    .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] addr_of(input int m);
    return (m == 0) ? AWADDR_M0 : (m == 1) ? AWADDR_M1 : AWADDR_M2;
  endfunction

  function automatic int len_of(input int m);
    return int'((m == 0) ? AWLEN_M0 : (m == 1) ? AWLEN_M1 : AWLEN_M2);
  endfunction

  // Model: phase 0 idle, 1 address, 2 data, 3 response
  int m_phase = 0, m_mst = 0, m_slv = 0, m_len = 0, m_beats = 0, m_rr = 0;
  bit m_err = 1'b0;

  always @(posedge ACLK or negedge ARESETn) begin : model
    int g;
    logic [31:0] a;
    if (!ARESETn) begin
      m_phase <= 0; m_mst <= 0; m_slv <= 0; m_len <= 0;
      m_beats <= 0; m_rr <= 0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      case (m_phase)
        0: if (AWVALID_M != 3'b000) begin
          g = -1;
          for (int k = 0; k < 3; k++)
            if (g < 0 && AWVALID_M[(m_rr + k) % 3]) g = (m_rr + k) % 3;
          a = addr_of(g);
          m_mst <= g;
          m_slv <= int'(a[18:16]);
          m_len <= len_of(g);
          m_phase <= 1;
        end
        1: if (AWVALID_M[m_mst] && AWREADY_S[m_slv]) begin
          m_phase <= 2;
          m_beats <= 0;
        end
        2: if (WVALID_M[m_mst] && WREADY_S[m_slv]) begin
          if (WLAST_M[m_mst] != (m_beats == m_len)) m_err <= 1'b1;
          m_beats <= m_beats + 1;
          if (m_beats == m_len) m_phase <= 3;
        end
        3: if (BVALID_S[m_slv] && BREADY_M[m_mst]) begin
          m_phase <= 0;
          m_rr <= (m_mst + 1) % 3;
          m_mst <= 0;
          m_slv <= 0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  function automatic logic [8:0] dut_vec();
    return {aw_sel_valid, w_sel_valid, b_sel_valid, sel_mst, sel_slv, wlast_err};
  endfunction

  always @(negedge ACLK) begin
    logic [8:0] e;
    if (chk_en) begin
      e = {m_phase == 1, m_phase == 2, m_phase == 3,
           2'(m_mst), 3'(m_slv), m_err};
      checks++;
      if (dut_vec() !== e) begin
        errors++;
        $display("FAIL model t=%0t act=%b req=%b", $time, dut_vec(), e);
      end
    end
    if (aw_sel_valid && !aw_prev) grants.push_back(int'(sel_mst));
    aw_prev <= aw_sel_valid;
    if (wlast_err) err_pulses <= err_pulses + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic run_write(input int m, input int aw_stall, input bit w_toggle,
                           input int wlast_at, input bit keep, input int resp_stall,
                           input logic [2:0] extra_req, output int lat,
                           output int g_mst, output int g_slv, output int beats);
    logic [31:0] a;
    int slv, len, wl, k;
    bit rdy;
    a = addr_of(m);
    slv = int'(a[18:16]);
    len = len_of(m);
    wl = (wlast_at < 0) ? len : wlast_at;
    AWVALID_M[m] = 1'b1;
    AWREADY_S = '0;
    lat = 0;
    while (!aw_sel_valid && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    if (!aw_sel_valid) tmo("aw_grant");
    g_mst = int'(sel_mst);
    g_slv = int'(sel_slv);
    for (int i = 0; i < aw_stall; i++) begin
      if (!keep) AWVALID_M[m] = (i != 2);
      @(negedge ACLK);
    end
    AWVALID_M[m] = 1'b1;
    AWREADY_S = 8'(1 << slv);
    k = 0;
    while (!w_sel_valid && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    if (!w_sel_valid) tmo("aw_hs");
    AWREADY_S = '0;
    if (!keep) AWVALID_M[m] = 1'b0;
    beats = 0;
    k = 0;
    while (w_sel_valid && k < 100) begin
      rdy = w_toggle ? (k % 2 == 0) : 1'b1;
      WVALID_M = 3'(1 << m);
      WREADY_S = rdy ? 8'(1 << slv) : 8'h00;
      WLAST_M = (beats == wl) ? 3'(1 << m) : 3'b000;
      @(negedge ACLK);
      if (rdy) beats++;
      k++;
    end
    if (w_sel_valid) tmo("w_burst");
    WVALID_M = '0;
    WREADY_S = '0;
    WLAST_M = '0;
    AWVALID_M = AWVALID_M | extra_req;
    for (int i = 0; i < resp_stall; i++) @(negedge ACLK);
    BVALID_S = 8'(1 << slv);
    BREADY_M = 3'(1 << m);
    k = 0;
    while (b_sel_valid && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    if (b_sel_valid) tmo("b_hs");
    BVALID_S = '0;
    BREADY_M = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gm, gs, nb, p0, k;
    int exp_rr[4];
    exp_rr = '{0, 1, 2, 0};
    repeat (2) @(negedge ACLK);
    chk("reset_outputs", 32'(dut_vec()), 0);
    ARESETn = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("idle_no_req", 32'(dut_vec()), 0);

    // Single write M1 -> S3, 4 beats
    AWADDR_M1 = 32'h0003_0000;
    AWLEN_M1 = 4'd3;
    p0 = err_pulses;
    run_write(1, 0, 1'b0, -1, 1'b0, 0, 3'b000, lat, gm, gs, nb);
    chk("single_lat", lat, 1);
    chk("single_mst", gm, 1);
    chk("single_slv", gs, 3);
    chk("single_beats", nb, 4);
    chk("single_noerr", err_pulses - p0, 0);
    chk("single_rr", m_rr, 2);

    // Reset in the middle of a DATA burst
    AWADDR_M2 = 32'h0007_0000;
    AWLEN_M2 = 4'd5;
    AWVALID_M = 3'b100;
    AWREADY_S = 8'h80;
    k = 0;
    while (!w_sel_valid && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    if (!w_sel_valid) tmo("rst_reach_data");
    AWVALID_M = '0;
    AWREADY_S = '0;
    WVALID_M = 3'b100;
    WREADY_S = 8'h80;
    repeat (2) @(negedge ACLK);
    #3 ARESETn = 1'b0;
    #1 chk("midburst_reset", 32'(dut_vec()), 0);
    WVALID_M = '0;
    WREADY_S = '0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("post_reset_idle", 32'(dut_vec()), 0);

    // Round-robin, all masters requesting
    AWADDR_M0 = 32'h0002_0000;
    AWADDR_M1 = 32'h0004_0000;
    AWADDR_M2 = 32'h0006_0000;
    AWLEN_M0 = 4'd0;
    AWLEN_M1 = 4'd0;
    AWLEN_M2 = 4'd0;
    grants.delete();
    AWVALID_M = 3'b111;
    for (int i = 0; i < 4; i++) begin
      run_write(exp_rr[i], 0, 1'b0, -1, 1'b1, 0, 3'b000, lat, gm, gs, nb);
      chk("rr_beats", nb, 1);
    end
    AWVALID_M = '0;
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk("rr_order", grants[i], exp_rr[i]);
    chk("rr_slv_m2", 32'h0006_0000 >> 16, 6);

    // Backpressure on AW and W
    AWADDR_M0 = 32'h0005_0000;
    AWLEN_M0 = 4'd3;
    p0 = err_pulses;
    run_write(0, 5, 1'b1, -1, 1'b0, 0, 3'b000, lat, gm, gs, nb);
    chk("bp_mst", gm, 0);
    chk("bp_slv", gs, 5);
    chk("bp_beats", nb, 4);
    chk("bp_noerr", err_pulses - p0, 0);

    // Early WLAST on second beat of a 3-beat burst
    AWADDR_M1 = 32'h0001_0000;
    AWLEN_M1 = 4'd2;
    p0 = err_pulses;
    run_write(1, 0, 1'b0, 1, 1'b0, 0, 3'b000, lat, gm, gs, nb);
    chk("wlast_beats", nb, 3);
    chk("wlast_pulses", err_pulses - p0, 2);

    // M2 requests while M0 is in RESP
    AWADDR_M0 = 32'h0000_0000;
    AWLEN_M0 = 4'd1;
    AWADDR_M2 = 32'h0004_0000;
    AWLEN_M2 = 4'd0;
    run_write(0, 0, 1'b0, -1, 1'b0, 3, 3'b100, lat, gm, gs, nb);
    chk("cont_m0_beats", nb, 2);
    chk("cont_idle_gap", aw_sel_valid, 0);
    @(negedge ACLK);
    chk("cont_grant", {aw_sel_valid, sel_mst, sel_slv}, {1'b1, 2'd2, 3'd4});
    run_write(2, 0, 1'b0, -1, 1'b0, 0, 3'b000, lat, gm, gs, nb);
    chk("cont_m2_beats", nb, 1);
    repeat (2) @(negedge ACLK);
    chk("final_idle", 32'(dut_vec()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
